// File: rtl/regfile_dump_streamer.sv
// Sweeps every register through the register file's debug read port and streams
// each one as {addr, pos, data MSB-first} bytes framed by SOF/EOF markers.
module regfile_dump_streamer #(
  parameter int         NUM_REGS = 32,
  parameter int         ADDR_W   = 5,
  parameter int         DATA_W   = 32,
  parameter int         TAG_W    = 4,
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter logic [7:0] EOF_BYTE = 8'h5A
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [ADDR_W-1:0] op_address_o,
  input  logic [DATA_W-1:0] reg_i,
  input  logic [TAG_W-1:0]  pos_i,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i
);

  localparam int NBYTES = 2 + DATA_W / 8;
  localparam int IDX_W  = $clog2(NBYTES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SOF     = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_EOF     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [IDX_W-1:0]  idx;
  logic              abort_pend;
  logic              aborted_q;
  logic [DATA_W-1:0] snap_data;
  logic [TAG_W-1:0]  snap_pos;
  logic              xfer;
  logic              abort_now;

  assign xfer         = byte_valid_o & byte_ready_i;
  assign busy_o       = (state != S_IDLE);
  assign done_o       = (state == S_DONE);
  assign aborted_o    = (state == S_DONE) & aborted_q;
  assign op_address_o = cnt;

  // An abort seen while a byte is stalled is remembered so the byte still completes.
  always_comb begin
    abort_now = 1'b0;
    if (state == S_ADDR || state == S_CAPTURE)
      abort_now = abort_i;
    else if (byte_valid_o)
      abort_now = xfer & (abort_i | abort_pend);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      abort_pend <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      if (byte_valid_o && !byte_ready_i && abort_i)
        abort_pend <= 1'b1;
      if (abort_now) begin
        state      <= S_DONE;
        aborted_q  <= 1'b1;
        abort_pend <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt        <= '0;
            aborted_q  <= 1'b0;
            abort_pend <= 1'b0;
            if (start_i) state <= S_SOF;
          end
          S_SOF: if (xfer) begin
            state <= S_ADDR;
            cnt   <= '0;
          end
          S_ADDR: state <= S_CAPTURE;
          S_CAPTURE: begin
            state <= S_SEND;
            idx   <= '0;
          end
          S_SEND: if (xfer) begin
            if (idx == IDX_W'(NBYTES - 1)) begin
              if (cnt == ADDR_W'(NUM_REGS - 1)) begin
                state <= S_EOF;
              end else begin
                cnt   <= cnt + 1'b1;
                state <= S_ADDR;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_EOF: if (xfer) state <= S_DONE;
          S_DONE: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Snapshot register: captures a same-register negedge write made during ADDR.
  always_ff @(posedge clk_i) begin
    if (state == S_CAPTURE) begin
      snap_data <= reg_i;
      snap_pos  <= pos_i;
    end
  end

  always_comb begin
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;
    case (state)
      S_SOF: begin
        byte_o       = SOF_BYTE;
        byte_valid_o = 1'b1;
      end
      S_EOF: begin
        byte_o       = EOF_BYTE;
        byte_valid_o = 1'b1;
      end
      S_SEND: begin
        byte_valid_o = 1'b1;
        if (idx == '0)
          byte_o = 8'(cnt);
        else if (idx == IDX_W'(1))
          byte_o = 8'(snap_pos);
        else
          for (int k = 0; k < DATA_W / 8; k++)
            if (idx == IDX_W'(k + 2)) byte_o = snap_data[DATA_W-1-8*k -: 8];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Directed bench for regfile_dump_streamer: a frame model built from the register
// image, checked byte-by-byte by one compare process, plus literal spot checks.
module tb_regfile_dump_streamer;

  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        byte_ready_i = 1'b0;
  logic        busy_o, done_o, aborted_o, byte_valid_o;
  logic [4:0]  op_address_o;
  logic [31:0] reg_i;
  logic [3:0]  pos_i;
  logic [7:0]  byte_o;

  logic [31:0] regs [32];
  logic [3:0]  tags [32];

  assign reg_i = regs[op_address_o];
  assign pos_i = tags[op_address_o];

  always #5 clk_i = ~clk_i;

  regfile_dump_streamer dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .aborted_o    (aborted_o),
    .op_address_o (op_address_o),
    .reg_i        (reg_i),
    .pos_i        (pos_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx [256];
  int         xcnt = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         exp_cycles = 0;
  int         refill = 0;
  bit         chk_en = 1'b0;
  bit         exp_abort = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected frame straight from the register image: SOF, {addr, tag, data MSB first} x32, EOF.
  function automatic void build_frame();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < 32; r++) begin
      exp_q.push_back(8'(r));
      exp_q.push_back({4'h0, tags[r]});
      for (int b = 3; b >= 0; b--) exp_q.push_back(regs[r][8*b +: 8]);
    end
    exp_q.push_back(8'h5A);
  endfunction

  always @(negedge clk_i) begin
    logic [7:0] e;
    if (!chk_en) begin
      xcnt       = 0;
      prev_stall = 1'b0;
    end else if (!reset) begin
      if (prev_stall) begin
        check_eq("stall_valid", 32'(byte_valid_o), 32'd1);
        check_eq("stall_byte", 32'(byte_o), 32'(prev_byte));
      end
      if (byte_valid_o && byte_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_byte", 32'(byte_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("stream_byte", 32'(byte_o), 32'(e));
        end
        if (xcnt < 256) rx[xcnt] = byte_o;
        xcnt++;
      end
      prev_stall = byte_valid_o && !byte_ready_i;
      prev_byte  = byte_o;
      if (busy_o) busy_cnt++;
      if (done_o) begin
        check_eq("frame_bytes_left", exp_q.size(), 0);
        check_eq("aborted_flag", 32'(aborted_o), 32'(exp_abort));
        if (exp_cycles != 0) check_eq("frame_cycles", busy_cnt, exp_cycles);
        done_cnt++;
        if (refill > 0) begin
          build_frame();
          refill--;
        end
      end
      if (!busy_o) busy_cnt = 0;
    end
  end

  task automatic setup(input int cyc, input bit ab);
    exp_q.delete();
    build_frame();
    exp_cycles = cyc;
    exp_abort  = ab;
    chk_en     = 1'b1;
  endtask

  task automatic end_test();
    chk_en = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_pulse();
    @(posedge clk_i);
    #1 start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk_i);
      #1;
      if (rnd) byte_ready_i = 1'($urandom_range(0, 1));
      n++;
    end
    check_eq("done_seen", done_cnt - d0, 1);
  endtask

  task automatic clear_image();
    for (int r = 0; r < 32; r++) begin
      regs[r] = 32'h0;
      tags[r] = 4'h0;
    end
  endtask

  initial begin
    int n;
    int d0;
    clear_image();
    regs[5] = 32'hDEADBEEF;
    tags[5] = 4'h3;
    #12;
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_aborted", 32'(aborted_o), 0);
    check_eq("rst_addr", 32'(op_address_o), 0);
    check_eq("rst_valid", 32'(byte_valid_o), 0);
    check_eq("rst_byte", 32'(byte_o), 0);
    @(posedge clk_i);
    #2 reset = 1'b0;
    byte_ready_i = 1'b1;

    // Full frame, ready tied high.
    setup(259, 1'b0);
    check_eq("model_len", exp_q.size(), 194);
    check_eq("model_sof", 32'(exp_q[0]), 32'hA5);
    check_eq("model_r5_addr", 32'(exp_q[31]), 32'h05);
    check_eq("model_r5_tag", 32'(exp_q[32]), 32'h03);
    check_eq("model_r5_msb", 32'(exp_q[33]), 32'hDE);
    check_eq("model_r5_lsb", 32'(exp_q[36]), 32'hEF);
    check_eq("model_eof", 32'(exp_q[193]), 32'h5A);
    start_pulse();
    wait_done(1'b0, 400);
    check_eq("t1_count", xcnt, 194);
    check_eq("t1_sof", 32'(rx[0]), 32'hA5);
    check_eq("t1_r5", {rx[33], rx[34], rx[35], rx[36]}, 32'hDEADBEEF);
    check_eq("t1_r5_hdr", 32'({rx[31], rx[32]}), 32'h0503);
    check_eq("t1_eof", 32'(rx[193]), 32'h5A);
    end_test();

    // Random backpressure on the same image.
    setup(0, 1'b0);
    start_pulse();
    wait_done(1'b1, 3000);
    byte_ready_i = 1'b1;
    check_eq("t2_count", xcnt, 194);
    check_eq("t2_r5_byte", 32'(rx[34]), 32'hAD);
    end_test();

    // Negedge write to r7 during its ADDR cycle is captured; one after CAPTURE is not.
    regs[7] = 32'h12345678;
    setup(0, 1'b0);
    regs[7] = 32'h0BADF00D;
    start_pulse();
    n = 0;
    while (!(busy_o && op_address_o == 5'd7 && !byte_valid_o) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("t3_addr_seen", 32'(n < 300), 1);
    regs[7] = 32'h12345678;
    n = 0;
    while (!(op_address_o == 5'd7 && byte_valid_o) && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    regs[7] = 32'hFFFFFFFF;
    wait_done(1'b0, 400);
    check_eq("t3_r7", {rx[45], rx[46], rx[47], rx[48]}, 32'h12345678);
    regs[7] = 32'h0;
    end_test();

    // Abort while byte 3 of r2 is stalled.
    regs[2] = 32'hCAFEB0BA;
    tags[2] = 4'h9;
    setup(0, 1'b1);
    while (exp_q.size() > 17) void'(exp_q.pop_back());
    start_pulse();
    n = 0;
    while (xcnt < 16 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    byte_ready_i = 1'b0;
    abort_i      = 1'b1;
    @(negedge clk_i);
    check_eq("t4_stall_valid", 32'(byte_valid_o), 1);
    check_eq("t4_stall_byte", 32'(byte_o), 32'hFE);
    repeat (4) @(posedge clk_i);
    #1 byte_ready_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    wait_done(1'b0, 10);
    check_eq("t4_count", xcnt, 17);
    check_eq("t4_last", 32'(rx[16]), 32'hFE);
    repeat (3) @(negedge clk_i);
    check_eq("t4_idle", 32'(busy_o), 0);
    end_test();
    regs[2] = 32'h0;
    tags[2] = 4'h0;

    // start_i held high: one frame, one idle cycle, then a fresh SOF.
    refill = 1;
    setup(259, 1'b0);
    d0 = done_cnt;
    @(posedge clk_i);
    #1 start_i = 1'b1;
    wait_done(1'b0, 400);
    @(negedge clk_i);
    check_eq("t5_idle_gap", 32'(busy_o), 0);
    @(negedge clk_i);
    check_eq("t5_resof_busy", 32'(busy_o), 1);
    check_eq("t5_resof_byte", 32'(byte_valid_o ? byte_o : 8'h00), 32'hA5);
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done(1'b0, 400);
    repeat (5) @(negedge clk_i);
    check_eq("t5_no_third", 32'(busy_o), 0);
    check_eq("t5_frames", done_cnt - d0, 2);
    end_test();

    // Asynchronous reset while sending r10.
    setup(0, 1'b0);
    start_pulse();
    n = 0;
    while (!(op_address_o == 5'd10 && byte_valid_o) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("t6_r10_seen", 32'(n < 300), 1);
    chk_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_eq("t6_valid", 32'(byte_valid_o), 0);
    check_eq("t6_busy", 32'(busy_o), 0);
    check_eq("t6_addr", 32'(op_address_o), 0);
    check_eq("t6_done", 32'(done_o), 0);
    @(posedge clk_i);
    #2 reset = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    setup(259, 1'b0);
    start_pulse();
    wait_done(1'b0, 400);
    check_eq("t6_count", xcnt, 194);
    check_eq("t6_sof", 32'(rx[0]), 32'hA5);
    check_eq("t6_eof", 32'(rx[193]), 32'h5A);
    end_test();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
